// File: rtl/code_lock_pkg.sv
// ---------------------------------------------------------------------------
// code_lock_pkg
// Shared types and constants for the keypad code-lock controller:
//   lock_state_e : controller state, same encoding as the state output
//   tone_e       : buzzer tone selector
//   KEY_*        : keypad codes above the decimal digits
//   NIB_*        : display nibbles for blank / open / set-code fill
//   bcd2_dec     : decrement a two-digit BCD value (lockout countdown)
// ---------------------------------------------------------------------------
package code_lock_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_SET_NEW = 2'd2,
        ST_LOCKOUT = 2'd3
    } lock_state_e;

    typedef enum logic [1:0] {
        TONE_KEY = 2'd0,
        TONE_OK  = 2'd1,
        TONE_ERR = 2'd2
    } tone_e;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_SET   = 4'hD;
    localparam logic [3:0] KEY_LOCK  = 4'hE;

    localparam logic [3:0] NIB_BLANK = 4'hF;
    localparam logic [3:0] NIB_OPEN  = 4'hA;
    localparam logic [3:0] NIB_SET   = 4'hD;

    // Two-digit BCD decrement; caller guarantees the value is non-zero.
    function automatic logic [7:0] bcd2_dec(input logic [7:0] v);
        logic [7:0] res;
        if (v[3:0] == 4'd0) begin
            res = {v[7:4] - 4'd1, 4'd9};
        end else begin
            res = {v[7:4], v[3:0] - 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/code_lock_ctrl_if.sv
// ---------------------------------------------------------------------------
// code_lock_ctrl_if
// Bundle between the keypad decoder / display+buzzer side and the lock core.
//   key_valid  : one-cycle strobe, key_code valid
//   key_code   : 0-9 digit, A enter, B back, C clear, D set, E lock, F none
//   disp       : nibble per digit, LSN rightmost, F blank
//   state      : 0 ENTRY, 1 OPEN, 2 SET_NEW, 3 LOCKOUT
//   tries_left : failures remaining before lockout
//   unlocked   : high in OPEN and SET_NEW
//   buzzer     : square-wave tone
// master = keypad/display side, slave = lock controller.
// ---------------------------------------------------------------------------
interface code_lock_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  key_valid;
    logic [3:0]            key_code;
    logic [4*DIGITS-1:0]   disp;
    logic [1:0]            state;
    logic [3:0]            tries_left;
    logic                  unlocked;
    logic                  buzzer;

    modport master (
        output key_valid, key_code,
        input  disp, state, tries_left, unlocked, buzzer
    );

    modport slave (
        input  key_valid, key_code,
        output disp, state, tries_left, unlocked, buzzer
    );
endinterface

// File: rtl/tone_gen.sv
// ---------------------------------------------------------------------------
// tone_gen
// Plays one tone per start strobe; a new strobe restarts the pattern.
// ERR tone is split into on / silent / on thirds of its length.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_start    : one-cycle tone request
//   i_tone     : tone selected with i_start
//   o_buzzer   : registered square wave, 0 when idle
// ---------------------------------------------------------------------------
module tone_gen
    import code_lock_pkg::*;
#(
    parameter int HP_KEY  = 50_000,
    parameter int HP_OK   = 25_000,
    parameter int HP_ERR  = 100_000,
    parameter int LEN_KEY = 10_000_000,
    parameter int LEN_OK  = 30_000_000,
    parameter int LEN_ERR = 15_000_000
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_start,
    input  tone_e i_tone,
    output logic  o_buzzer
);
    logic        r_active;
    tone_e       r_tone;
    logic [31:0] r_elapsed;
    logic [31:0] r_hp_cnt;
    logic        r_phase;
    logic        r_buzzer;

    logic [31:0] w_hp;
    logic [31:0] w_len;
    logic        w_gap;

    // Half-period and length of the tone in progress, plus ERR silent window
    always_comb begin
        w_hp  = 32'(HP_KEY);
        w_len = 32'(LEN_KEY);
        case (r_tone)
            TONE_KEY: begin
                w_hp  = 32'(HP_KEY);
                w_len = 32'(LEN_KEY);
            end
            TONE_OK: begin
                w_hp  = 32'(HP_OK);
                w_len = 32'(LEN_OK);
            end
            TONE_ERR: begin
                w_hp  = 32'(HP_ERR);
                w_len = 32'(LEN_ERR);
            end
            default: begin
                w_hp  = 32'(HP_KEY);
                w_len = 32'(LEN_KEY);
            end
        endcase
        if (r_tone == TONE_ERR) begin
            w_gap = (r_elapsed >= (w_len / 32'd3)) &&
                    (r_elapsed < ((w_len / 32'd3) * 32'd2));
        end else begin
            w_gap = 1'b0;
        end
    end

    // Tone sequencer: start strobe restarts, otherwise run to the end of length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= 1'b0;
            r_tone    <= TONE_KEY;
            r_elapsed <= 32'd0;
            r_hp_cnt  <= 32'd0;
            r_phase   <= 1'b0;
        end else if (i_start) begin
            r_active  <= 1'b1;
            r_tone    <= i_tone;
            r_elapsed <= 32'd0;
            r_hp_cnt  <= 32'd0;
            r_phase   <= 1'b1;
        end else if (r_active) begin
            if (r_elapsed == (w_len - 32'd1)) begin
                r_active <= 1'b0;
            end
            r_elapsed <= r_elapsed + 32'd1;
            if (r_hp_cnt == (w_hp - 32'd1)) begin
                r_hp_cnt <= 32'd0;
                r_phase  <= ~r_phase;
            end else begin
                r_hp_cnt <= r_hp_cnt + 32'd1;
            end
        end
    end

    // Registered buzzer pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buzzer <= 1'b0;
        end else begin
            r_buzzer <= r_active & r_phase & ~w_gap;
        end
    end

    assign o_buzzer = r_buzzer;

endmodule

// File: rtl/code_lock_ctrl.sv
// ---------------------------------------------------------------------------
// code_lock_ctrl
// Keypad code lock: collects DIGITS key presses, compares with the stored
// code, opens on match, locks out for LOCKOUT_S seconds after MAX_TRIES
// consecutive failures. The code may be re-programmed only while open.
//   clk, rst_n : clock, asynchronous active-low reset
//   lock_bus   : code_lock_ctrl_if.slave (keys in; disp, state,
//                tries_left, unlocked, buzzer out - all registered)
// Pipeline: keys are captured, act one cycle later, outputs follow a cycle after.
// ---------------------------------------------------------------------------
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int                  DIGITS       = 4,
    parameter int                  MAX_TRIES    = 3,
    parameter int                  LOCKOUT_S    = 30,
    parameter int                  TICK_CYCLES  = 50_000_000,
    parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 16'h0246,
    parameter int                  HP_KEY       = 50_000,
    parameter int                  HP_OK        = 25_000,
    parameter int                  HP_ERR       = 100_000,
    parameter int                  LEN_KEY      = TICK_CYCLES / 5,
    parameter int                  LEN_OK       = TICK_CYCLES * 3 / 5,
    parameter int                  LEN_ERR      = TICK_CYCLES * 3 / 10
) (
    input logic             clk,
    input logic             rst_n,
    code_lock_ctrl_if.slave lock_bus
);
    localparam logic [3:0] DIGITS_C = 4'(DIGITS);
    localparam logic [7:0] LOCK_BCD = {4'(LOCKOUT_S / 10), 4'(LOCKOUT_S % 10)};

    logic                r_key_vld;
    logic [3:0]          r_key;
    lock_state_e         r_state;
    logic [4*DIGITS-1:0] r_entry;
    logic [4*DIGITS-1:0] r_code;
    logic [3:0]          r_count;
    logic [3:0]          r_tries;
    logic [7:0]          r_secs;
    logic [31:0]         r_presc;
    logic                r_req_key;
    logic                r_req_ok;
    logic                r_req_err;

    logic [4*DIGITS-1:0] r_disp;
    logic [1:0]          r_state_o;
    logic [3:0]          r_tries_o;
    logic                r_unlocked;

    logic [3:0]          w_fill;
    logic [4*DIGITS-1:0] w_disp;
    logic                w_tone_start;
    tone_e               w_tone_id;

    // Unfilled entry positions show D while programming a new code
    assign w_fill = (r_state == ST_SET_NEW) ? NIB_SET : NIB_BLANK;

    // Main controller: key capture, entry buffer, code compare, lockout timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_vld <= 1'b0;
            r_key     <= 4'h0;
            r_state   <= ST_ENTRY;
            r_entry   <= {DIGITS{NIB_BLANK}};
            r_code    <= DEFAULT_CODE;
            r_count   <= 4'd0;
            r_tries   <= 4'(MAX_TRIES);
            r_secs    <= 8'h00;
            r_presc   <= 32'd0;
            r_req_key <= 1'b0;
            r_req_ok  <= 1'b0;
            r_req_err <= 1'b0;
        end else begin
            // Keys arriving during lockout are dropped at capture
            r_key_vld <= lock_bus.key_valid && (r_state != ST_LOCKOUT);
            r_key     <= lock_bus.key_code;
            r_req_key <= 1'b0;
            r_req_ok  <= 1'b0;
            r_req_err <= 1'b0;
            case (r_state)
                ST_ENTRY, ST_SET_NEW: begin
                    if (r_key_vld) begin
                        if (r_key <= 4'd9) begin
                            if (r_count < DIGITS_C) begin
                                r_entry   <= {r_entry[4*DIGITS-5:0], r_key};
                                r_count   <= r_count + 4'd1;
                                r_req_key <= 1'b1;
                            end
                        end else begin
                            case (r_key)
                                KEY_BACK: begin
                                    if (r_count != 4'd0) begin
                                        r_entry   <= {w_fill, r_entry[4*DIGITS-1:4]};
                                        r_count   <= r_count - 4'd1;
                                        r_req_key <= 1'b1;
                                    end
                                end
                                KEY_CLEAR: begin
                                    r_entry   <= {DIGITS{w_fill}};
                                    r_count   <= 4'd0;
                                    r_req_key <= 1'b1;
                                end
                                KEY_ENTER: begin
                                    if (r_count == DIGITS_C) begin
                                        r_entry <= {DIGITS{NIB_BLANK}};
                                        r_count <= 4'd0;
                                        if (r_state == ST_SET_NEW) begin
                                            r_code   <= r_entry;
                                            r_req_ok <= 1'b1;
                                            r_state  <= ST_ENTRY;
                                        end else if (r_entry == r_code) begin
                                            r_state  <= ST_OPEN;
                                            r_tries  <= 4'(MAX_TRIES);
                                            r_req_ok <= 1'b1;
                                        end else begin
                                            r_req_err <= 1'b1;
                                            r_tries   <= r_tries - 4'd1;
                                            if (r_tries == 4'd1) begin
                                                r_state <= ST_LOCKOUT;
                                                r_secs  <= LOCK_BCD;
                                                r_presc <= 32'd0;
                                            end
                                        end
                                    end
                                end
                                KEY_LOCK: begin
                                    if (r_state == ST_SET_NEW) begin
                                        r_state <= ST_ENTRY;
                                        r_entry <= {DIGITS{NIB_BLANK}};
                                        r_count <= 4'd0;
                                    end
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
                ST_OPEN: begin
                    if (r_key_vld) begin
                        if (r_key == KEY_LOCK) begin
                            r_state <= ST_ENTRY;
                            r_entry <= {DIGITS{NIB_BLANK}};
                            r_count <= 4'd0;
                        end else if (r_key == KEY_SET) begin
                            r_state <= ST_SET_NEW;
                            r_entry <= {DIGITS{NIB_SET}};
                            r_count <= 4'd0;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    // 00 is held for a full second before returning to ENTRY
                    if (r_presc == 32'(TICK_CYCLES - 1)) begin
                        r_presc <= 32'd0;
                        if (r_secs == 8'h00) begin
                            r_state <= ST_ENTRY;
                            r_tries <= 4'(MAX_TRIES);
                        end else begin
                            r_secs    <= bcd2_dec(r_secs);
                            r_req_key <= 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + 32'd1;
                    end
                end
                default: begin
                    r_state <= ST_ENTRY;
                end
            endcase
        end
    end

    // Display content for the current state
    always_comb begin
        w_disp = {DIGITS{NIB_BLANK}};
        case (r_state)
            ST_ENTRY, ST_SET_NEW: w_disp = r_entry;
            ST_OPEN:              w_disp = {DIGITS{NIB_OPEN}};
            ST_LOCKOUT:           w_disp[7:0] = r_secs;
            default:              w_disp = {DIGITS{NIB_BLANK}};
        endcase
    end

    // Tone request priority: ERR over OK over KEY
    always_comb begin
        w_tone_start = r_req_err | r_req_ok | r_req_key;
        if (r_req_err) begin
            w_tone_id = TONE_ERR;
        end else if (r_req_ok) begin
            w_tone_id = TONE_OK;
        end else begin
            w_tone_id = TONE_KEY;
        end
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp     <= {DIGITS{NIB_BLANK}};
            r_state_o  <= 2'd0;
            r_tries_o  <= 4'(MAX_TRIES);
            r_unlocked <= 1'b0;
        end else begin
            r_disp     <= w_disp;
            r_state_o  <= r_state;
            r_tries_o  <= r_tries;
            r_unlocked <= (r_state == ST_OPEN) || (r_state == ST_SET_NEW);
        end
    end

    tone_gen #(
        .HP_KEY  (HP_KEY),
        .HP_OK   (HP_OK),
        .HP_ERR  (HP_ERR),
        .LEN_KEY (LEN_KEY),
        .LEN_OK  (LEN_OK),
        .LEN_ERR (LEN_ERR)
    ) u_tone_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_tone_start),
        .i_tone   (w_tone_id),
        .o_buzzer (lock_bus.buzzer)
    );

    assign lock_bus.disp       = r_disp;
    assign lock_bus.state      = r_state_o;
    assign lock_bus.tries_left = r_tries_o;
    assign lock_bus.unlocked   = r_unlocked;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_code_lock_ctrl
// Directed and random key sequences against a behavioural model of the lock
// (entered digits in a queue, code in an array, tones as on/off counts).
// ---------------------------------------------------------------------------
module tb_code_lock_ctrl;
    localparam int D      = 4;
    localparam int MAXT   = 3;
    localparam int LOCK_S = 30;
    localparam int TICK   = 100;
    localparam int HPK    = 3;
    localparam int HPO    = 2;
    localparam int HPE    = 5;
    localparam int LK     = 20;
    localparam int LO     = 60;
    localparam int LE     = 30;
    localparam int WIN    = 75;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    code_lock_ctrl_if #(.DIGITS(D)) bus ();

    code_lock_ctrl #(
        .DIGITS       (D),
        .MAX_TRIES    (MAXT),
        .LOCKOUT_S    (LOCK_S),
        .TICK_CYCLES  (TICK),
        .DEFAULT_CODE (16'h0246),
        .HP_KEY       (HPK),
        .HP_OK        (HPO),
        .HP_ERR       (HPE),
        .LEN_KEY      (LK),
        .LEN_OK       (LO),
        .LEN_ERR      (LE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lock_bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: 0 ENTRY, 1 OPEN, 2 SET_NEW, 3 LOCKOUT; tone 0 none, 1 key, 2 ok, 3 err
    int m_state;
    int m_q[$];
    int m_code[D];
    int m_tries;
    int m_tone;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_q.delete();
        m_code[0] = 0; m_code[1] = 2; m_code[2] = 4; m_code[3] = 6;
        m_tries = MAXT;
        m_tone  = 0;
    endtask

    task automatic model_key(input int k);
        int ok;
        m_tone = 0;
        case (m_state)
            0, 2: begin
                if (k <= 9) begin
                    if (m_q.size() < D) begin
                        m_q.push_back(k);
                        m_tone = 1;
                    end
                end else if (k == 11) begin
                    if (m_q.size() > 0) begin
                        void'(m_q.pop_back());
                        m_tone = 1;
                    end
                end else if (k == 12) begin
                    m_q.delete();
                    m_tone = 1;
                end else if (k == 10 && m_q.size() == D) begin
                    if (m_state == 0) begin
                        ok = 1;
                        for (int i = 0; i < D; i++) if (m_q[i] != m_code[i]) ok = 0;
                        if (ok == 1) begin
                            m_state = 1;
                            m_tries = MAXT;
                            m_tone  = 2;
                        end else begin
                            m_tries = m_tries - 1;
                            m_tone  = 3;
                            if (m_tries == 0) m_state = 3;
                        end
                    end else begin
                        for (int i = 0; i < D; i++) m_code[i] = m_q[i];
                        m_tone  = 2;
                        m_state = 0;
                    end
                    m_q.delete();
                end else if (k == 14 && m_state == 2) begin
                    m_state = 0;
                    m_q.delete();
                end
            end
            1: begin
                if (k == 14) begin
                    m_state = 0;
                    m_q.delete();
                end else if (k == 13) begin
                    m_state = 2;
                    m_q.delete();
                end
            end
            default: begin
            end
        endcase
    endtask

    function automatic logic [31:0] model_disp();
        logic [31:0] v;
        int fill;
        v = 32'd0;
        fill = (m_state == 2) ? 13 : 15;
        for (int i = 0; i < D; i++) v[4*i +: 4] = (m_state == 1) ? 4'hA : 4'(fill);
        if (m_state == 0 || m_state == 2)
            for (int i = 0; i < m_q.size(); i++) v[4*(m_q.size()-1-i) +: 4] = 4'(m_q[i]);
        return v;
    endfunction

    // Number of high cycles and longest high run of a complete tone
    task automatic tone_expect(input int tone, output int highs, output int run);
        int hp, len, cur;
        bit on;
        highs = 0; run = 0; cur = 0; hp = 1; len = 0;
        case (tone)
            1: begin hp = HPK; len = LK; end
            2: begin hp = HPO; len = LO; end
            3: begin hp = HPE; len = LE; end
            default: len = 0;
        endcase
        for (int t = 0; t < len; t++) begin
            on = ((t / hp) % 2 == 0) && !(tone == 3 && t >= len / 3 && t < 2 * len / 3);
            if (on) begin
                highs++;
                cur++;
                if (cur > run) run = cur;
            end else begin
                cur = 0;
            end
        end
    endtask

    task automatic send_key(input int k);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'(k);
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
    endtask

    // Lockout: countdown sampled mid-second, ignored keys, release after LOCK_S+1 s
    task automatic check_lockout();
        int pts[5] = '{50, 150, 1550, 3050, 3150};
        int t, sec;
        logic [31:0] ev;
        t = 0;
        for (int i = 0; i < 5; i++) begin
            repeat (pts[i] - t) @(negedge clk);
            t = pts[i];
            if (pts[i] / TICK <= LOCK_S) begin
                sec = LOCK_S - pts[i] / TICK;
                ev = 32'd0;
                for (int j = 0; j < D; j++) ev[4*j +: 4] = 4'hF;
                ev[7:0] = {4'(sec / 10), 4'(sec % 10)};
                check_eq($sformatf("lock_disp@%0d", pts[i]), 32'(bus.disp), ev);
                check_eq($sformatf("lock_state@%0d", pts[i]), 32'(bus.state), 32'd3);
                check_eq($sformatf("lock_tries@%0d", pts[i]), 32'(bus.tries_left), 32'd0);
                check_eq($sformatf("lock_unl@%0d", pts[i]), 32'(bus.unlocked), 32'd0);
            end else begin
                m_state = 0;
                m_tries = MAXT;
                m_q.delete();
                check_eq("unlock_state", 32'(bus.state), 32'd0);
                check_eq("unlock_tries", 32'(bus.tries_left), 32'(MAXT));
                check_eq("unlock_disp", 32'(bus.disp), model_disp());
            end
            if (i == 1) begin
                send_key(7);
                send_key(10);
                t = t + 4;
            end
        end
    endtask

    task automatic do_key(input int k);
        int prev, eh, er, h, r, cur;
        prev = m_state;
        model_key(k);
        send_key(k);
        if (m_state == 3 && prev != 3) begin
            check_lockout();
            return;
        end
        h = 0; r = 0; cur = 0;
        repeat (WIN) begin
            @(negedge clk);
            if (bus.buzzer === 1'b1) begin
                h++;
                cur++;
                if (cur > r) r = cur;
            end else begin
                cur = 0;
            end
        end
        tone_expect(m_tone, eh, er);
        check_eq($sformatf("disp k=%0h", k), 32'(bus.disp), model_disp());
        check_eq($sformatf("state k=%0h", k), 32'(bus.state), 32'(m_state));
        check_eq($sformatf("tries k=%0h", k), 32'(bus.tries_left), 32'(m_tries));
        check_eq($sformatf("unlocked k=%0h", k), 32'(bus.unlocked), 32'((m_state == 1 || m_state == 2) ? 1 : 0));
        check_eq($sformatf("buzz_high k=%0h", k), 32'(h), 32'(eh));
        check_eq($sformatf("buzz_run k=%0h", k), 32'(r), 32'(er));
    endtask

    // Keys given as nibbles, first key in the most significant used nibble
    task automatic do_keys(input logic [31:0] seq, input int n);
        for (int i = 0; i < n; i++) do_key(int'(seq[4*(n-1-i) +: 4]));
    endtask

    task automatic enter_code();
        int c[D];
        for (int i = 0; i < D; i++) c[i] = m_code[i];
        for (int i = 0; i < D; i++) do_key(c[i]);
        do_key(10);
    endtask

    initial begin
        int r;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_disp", 32'(bus.disp), 32'h0000_FFFF);
        check_eq("rst_buzzer", 32'(bus.buzzer), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_disp", 32'(bus.disp), 32'h0000_FFFF);
        check_eq("idle_state", 32'(bus.state), 32'd0);
        check_eq("idle_tries", 32'(bus.tries_left), 32'(MAXT));
        check_eq("idle_unlocked", 32'(bus.unlocked), 32'd0);

        // Open with default code, edit entry, ignored short enter
        do_keys(32'h0246A, 5);
        do_keys(32'hE, 1);
        do_keys(32'h123BB9, 6);
        do_keys(32'hA, 1);
        do_keys(32'hC, 1);
        // Three failures into lockout
        do_keys(32'h1111A, 5);
        do_keys(32'h2222A, 5);
        do_keys(32'h3333A, 5);
        // Reprogram code and confirm old one fails
        do_keys(32'h0246A, 5);
        do_keys(32'hD5555A, 6);
        do_keys(32'h0246A, 5);
        do_keys(32'h5555A, 5);
        do_keys(32'hE, 1);

        // Random keys, with occasional correct code entry
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 19);
            if (r < 12) do_key($urandom_range(0, 9));
            else if (r < 18) do_key(r - 2);
            else enter_code();
        end

        // Program 7777, then reset mid-entry while the key tone sounds
        do_keys(32'hE, 1);
        do_keys(32'hC, 1);
        enter_code();
        do_keys(32'hD7777A, 6);
        send_key(5);
        repeat (3) @(negedge clk);
        check_eq("pre_rst_buzzer", 32'(bus.buzzer), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_disp", 32'(bus.disp), 32'h0000_FFFF);
        check_eq("mid_rst_buzzer", 32'(bus.buzzer), 32'd0);
        check_eq("mid_rst_state", 32'(bus.state), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        do_keys(32'h0246A, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
